// File: rtl/wb_gpio_irq_bank.sv
// Wishbone-slave GPIO bank: per-pin output value, output enable, synchronised
// input, edge-detect status and routing of pending interrupts onto irq lines.
module wb_gpio_irq_bank #(
  parameter int unsigned NUM_IO      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_IRQ     = 3
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NUM_IO-1:0]    io_in,
  output logic [NUM_IO-1:0]    io_out,
  output logic [NUM_IO-1:0]    io_oeb,
  output logic [NUM_IRQ-1:0]   irq
);

  localparam int unsigned RW = 2 * NUM_IO;

  logic [NUM_IO-1:0]  out_q, out_d;
  logic [NUM_IO-1:0]  oeb_q, oeb_d;
  logic [NUM_IO-1:0]  rise_en_q, rise_en_d;
  logic [NUM_IO-1:0]  fall_en_q, fall_en_d;
  logic [NUM_IO-1:0]  sts_q, sts_d;
  logic [RW-1:0]      route_q, route_d;
  logic [NUM_IO-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0]  prev_q;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;

  logic               req_c, acc_c;
  logic [31:0]        wmask_c, rdata_c;
  logic [NUM_IO-1:0]  sync_c, rise_c, fall_c, clr_c;

  assign req_c   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc_c   = req_c & ~ack_q;
  assign wmask_c = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign sync_c  = sync_q[SYNC_STAGES-1];
  assign rise_c  = sync_c & ~prev_q;
  assign fall_c  = ~sync_c & prev_q;

  // Read data mux over the register window
  always_comb begin
    rdata_c = '0;
    case (wbs_adr_i[7:0])
      8'h00:   rdata_c = 32'(out_q);
      8'h04:   rdata_c = 32'(oeb_q);
      8'h08:   rdata_c = 32'(sync_c);
      8'h0C:   rdata_c = 32'(rise_en_q);
      8'h10:   rdata_c = 32'(fall_en_q);
      8'h14:   rdata_c = 32'(sts_q);
      8'h18:   rdata_c = 32'(route_q);
      default: rdata_c = '0;
    endcase
  end

  // Next-state: register writes, W1C status, irq routing, bus handshake
  always_comb begin
    out_d     = out_q;
    oeb_d     = oeb_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    route_d   = route_q;
    clr_c     = '0;
    irq_d     = '0;
    if (acc_c && wbs_we_i) begin
      case (wbs_adr_i[7:0])
        8'h00: out_d = (out_q & ~wmask_c[NUM_IO-1:0]) | (wbs_dat_i[NUM_IO-1:0] & wmask_c[NUM_IO-1:0]);
        8'h04: oeb_d = (oeb_q & ~wmask_c[NUM_IO-1:0]) | (wbs_dat_i[NUM_IO-1:0] & wmask_c[NUM_IO-1:0]);
        8'h0C: rise_en_d = (rise_en_q & ~wmask_c[NUM_IO-1:0]) | (wbs_dat_i[NUM_IO-1:0] & wmask_c[NUM_IO-1:0]);
        8'h10: fall_en_d = (fall_en_q & ~wmask_c[NUM_IO-1:0]) | (wbs_dat_i[NUM_IO-1:0] & wmask_c[NUM_IO-1:0]);
        8'h14: clr_c = wbs_dat_i[NUM_IO-1:0] & wmask_c[NUM_IO-1:0];
        8'h18: route_d = (route_q & ~wmask_c[RW-1:0]) | (wbs_dat_i[RW-1:0] & wmask_c[RW-1:0]);
        default: ;
      endcase
    end
    // A fresh edge wins over a simultaneous clear
    sts_d = (rise_c & rise_en_q) | (fall_c & fall_en_q) | (sts_q & ~clr_c);
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      for (int i = 0; i < int'(NUM_IO); i++) begin
        if (sts_q[i] && (route_q[2*i +: 2] == 2'(k))) irq_d[k] = 1'b1;
      end
    end
    ack_d = acc_c;
    dat_d = (acc_c && !wbs_we_i) ? rdata_c : 32'h0;
  end

  // State registers, synchroniser chain and registered outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      sts_q     <= '0;
      route_q   <= '0;
      prev_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= '0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      out_q     <= out_d;
      oeb_q     <= oeb_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      sts_q     <= sts_d;
      route_q   <= route_d;
      prev_q    <= sync_c;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
      sync_q[0] <= io_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq       = irq_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_gpio_irq_bank.sv
// Directed self-checking bench for wb_gpio_irq_bank (default parameters).
`timescale 1ns/1ps
module tb_wb_gpio_irq_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_in, io_out, io_oeb;
  logic [2:0]  irq;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] B = 32'h3000_0000;

  wb_gpio_irq_bank #(.NUM_IO(16), .BASE_ADDR(32'h3000_0000), .SYNC_STAGES(2), .NUM_IRQ(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One Wishbone access; returns read data and cycles to ack (-1 if none within budget)
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output int lat);
    if (ack) begin @(posedge clk); #1; end
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    rd = '0; lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ack) begin rd = rdat; lat = c; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; io_in = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (io_oeb !== 16'hFFFF) begin n_bad++; $display("FAIL reset_oeb: got %h want ffff", io_oeb); end
    n_cmp++; if (io_out !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", io_out); end
    n_cmp++; if (irq !== 3'b000) begin n_bad++; $display("FAIL reset_irq: got %b want 000", irq); end
    n_cmp++; if (ack !== 1'b0 || rdat !== 32'h0) begin n_bad++; $display("FAIL reset_bus: got ack=%b dat=%h want 0/0", ack, rdat); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_oeb_read();
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, B + 32'h04, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (lat !== 1 || rd !== 32'h0000FFFF) begin n_bad++; $display("FAIL read_oeb: got %h lat %0d want 0000ffff lat 1", rd, lat); end
    wb_xfer(1'b1, B + 32'h04, 4'hF, 32'h0000_00F0, rd, lat);
    n_cmp++; if (io_oeb !== 16'h00F0) begin n_bad++; $display("FAIL write_oeb: got %h want 00f0", io_oeb); end
  endtask

  task automatic test_out_bytelanes();
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, B + 32'h00, 4'b0001, 32'h0000_A5C3, rd, lat);
    n_cmp++; if (lat !== 1 || io_out !== 16'h00C3) begin n_bad++; $display("FAIL out_sel1: got %h lat %0d want 00c3 lat 1", io_out, lat); end
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL ack_pulse: got %b want 0", ack); end
    wb_xfer(1'b1, B + 32'h00, 4'b1111, 32'h0000_A5C3, rd, lat);
    n_cmp++; if (lat !== 1 || io_out !== 16'hA5C3) begin n_bad++; $display("FAIL out_selF: got %h lat %0d want a5c3 lat 1", io_out, lat); end
    wb_xfer(1'b0, B + 32'h00, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_A5C3) begin n_bad++; $display("FAIL read_out: got %h want 0000a5c3", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = B; sel = 4'hF;
    for (int c = 3; c >= 0; c--) begin
      @(posedge clk); #1;
      pat[c] = ack;
    end
    cyc = 0; stb = 0;
    n_cmp++; if (pat !== 4'b1010) begin n_bad++; $display("FAIL held_stb_ack: got %b want 1010", pat); end
    @(posedge clk); #1;
  endtask

  task automatic test_rise_irq();
    logic [31:0] rd; int lat; logic [2:0] i2;
    wb_xfer(1'b1, B + 32'h0C, 4'hF, 32'h0000_0008, rd, lat);
    wb_xfer(1'b1, B + 32'h18, 4'hF, 32'h0000_0040, rd, lat);
    @(posedge clk); #1;
    io_in = 16'h0008;
    @(posedge clk); #1;  // edge N
    @(posedge clk); #1;
    @(posedge clk); #1;  // edge N+2: status set, irq not yet
    i2 = irq;
    @(posedge clk); #1;  // edge N+3
    n_cmp++; if (i2 !== 3'b000) begin n_bad++; $display("FAIL irq_early: got %b want 000", i2); end
    n_cmp++; if (irq !== 3'b010) begin n_bad++; $display("FAIL irq_route1: got %b want 010", irq); end
    wb_xfer(1'b0, B + 32'h14, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_0008) begin n_bad++; $display("FAIL status_rise: got %h want 00000008", rd); end
    wb_xfer(1'b0, B + 32'h08, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_0008) begin n_bad++; $display("FAIL in_pin3: got %h want 00000008", rd); end
  endtask

  task automatic test_w1c();
    logic [31:0] rd; int lat;
    io_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    io_in = 16'h0008;
    @(posedge clk); #1;  // edge N
    @(posedge clk); #1;  // edge N+1; the write below acks at N+2
    wb_xfer(1'b1, B + 32'h14, 4'hF, 32'h0000_0008, rd, lat);
    wb_xfer(1'b0, B + 32'h14, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_0008) begin n_bad++; $display("FAIL set_beats_clear: got %h want 00000008", rd); end
    repeat (2) @(posedge clk);
    #1;
    wb_xfer(1'b1, B + 32'h14, 4'hF, 32'h0000_0008, rd, lat);
    n_cmp++; if (irq !== 3'b010) begin n_bad++; $display("FAIL irq_hold_after_clr: got %b want 010", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 3'b000) begin n_bad++; $display("FAIL irq_fall: got %b want 000", irq); end
    wb_xfer(1'b0, B + 32'h14, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL status_cleared: got %h want 0", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] rd; int lat; int seen;
    wb_xfer(1'b0, B + 32'h1C, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (lat !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL read_1c: got %h lat %0d want 0 lat 1", rd, lat); end
    seen = 0;
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0100; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack) seen++;
    end
    cyc = 0; stb = 0; we = 0;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL out_of_window: got %0d acks want 0", seen); end
    n_cmp++; if (io_out !== 16'hA5C3) begin n_bad++; $display("FAIL out_of_window_wr: got %h want a5c3", io_out); end
    io_in = 16'h1234;
    repeat (4) @(posedge clk);
    #1;
    wb_xfer(1'b0, B + 32'h08, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL read_in: got %h want 00001234", rd); end
    wb_xfer(1'b1, B + 32'h08, 4'hF, 32'h0000_FFFF, rd, lat);
    wb_xfer(1'b0, B + 32'h08, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_1234) begin n_bad++; $display("FAIL in_read_only: got %h want 00001234", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic a1;
    // async drop of an active ack
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = B + 32'h04; sel = 4'hF;
    @(posedge clk); #1;
    a1 = ack;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (a1 !== 1'b1 || ack !== 1'b0 || rdat !== 32'h0) begin n_bad++; $display("FAIL async_ack_drop: got pre=%b ack=%b dat=%h want 1/0/0", a1, ack, rdat); end
    n_cmp++; if (io_out !== 16'h0 || io_oeb !== 16'hFFFF || irq !== 3'b0) begin n_bad++; $display("FAIL async_pads: got out=%h oeb=%h irq=%b want 0/ffff/0", io_out, io_oeb, irq); end
    cyc = 0; stb = 0;
    @(posedge clk); #1 rst = 1'b0;
    // write interrupted before its ack edge
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; adr = B; sel = 4'hF; wdat = 32'h0000_FFFF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0 || io_out !== 16'h0) begin n_bad++; $display("FAIL mid_write_rst: got ack=%b out=%h want 0/0000", ack, io_out); end
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1 rst = 1'b0;
    wb_xfer(1'b0, B, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (lat !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL out_after_rst: got %h lat %0d want 0 lat 1", rd, lat); end
    wb_xfer(1'b0, B + 32'h04, 4'hF, 32'h0, rd, lat);
    n_cmp++; if (rd !== 32'h0000_FFFF) begin n_bad++; $display("FAIL oeb_after_rst: got %h want 0000ffff", rd); end
  endtask

  initial begin
    test_reset();
    test_oeb_read();
    test_out_bytelanes();
    test_back_to_back();
    test_rise_irq();
    test_w1c();
    test_decode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
